// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: shared-memory endpoint downstream of the snoopy MSI bus arbiter.
// Serves BusRd/BusRdX fills after MEM_LATENCY cycles, absorbs flush/write-back
// lines, and cancels a pending fill when an M-state owner supplies the data.
// Optional build macro: BUS_MEM_CTRL_ERR_EN adds the sticky protocol-error output err_o.
module bus_mem_ctrl #(
    parameter int unsigned ADDR_SIZE       = 32,
    parameter int unsigned CACHE_LINE_SIZE = 128,
    parameter int unsigned MEM_LINES       = 16,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       bus_valid_i,
    input  logic [1:0]                 bus_msg_i,
    input  logic [ADDR_SIZE-1:0]       bus_addr_i,
    input  logic                       flush_i,
    input  logic [CACHE_LINE_SIZE-1:0] flush_data_i,
`ifdef BUS_MEM_CTRL_ERR_EN
    output logic                       err_o,
`endif
    output logic                       mem_busy_o,
    output logic [CACHE_LINE_SIZE-1:0] data_o,
    output logic                       data_valid_o
);

    localparam int unsigned OFF = $clog2(CACHE_LINE_SIZE / 8);
    localparam int unsigned IDX = $clog2(MEM_LINES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [CACHE_LINE_SIZE-1:0] RESET_LINE = {CACHE_LINE_SIZE/16{16'hCAFE}};

    logic [1:0]                 r_state;
    logic [3:0]                 r_cnt;
    logic [IDX-1:0]             r_idx;
    logic                       r_busy;
    logic                       r_data_valid;
    logic [CACHE_LINE_SIZE-1:0] r_data;
    logic [CACHE_LINE_SIZE-1:0] r_mem [MEM_LINES];

    logic [IDX-1:0]             w_idx;
    logic                       w_rd_req;
    logic                       w_flush;
    logic                       w_we;
    logic [IDX-1:0]             w_widx;
    logic                       w_unused_addr;

    // Upper address bits and byte offset do not select a line; lines alias modulo MEM_LINES.
    assign w_idx         = bus_addr_i[OFF+IDX-1:OFF];
    assign w_unused_addr = ^{bus_addr_i[ADDR_SIZE-1:OFF+IDX], bus_addr_i[OFF-1:0]};
    assign w_rd_req      = bus_valid_i && !bus_msg_i[1] && !flush_i;
    assign w_flush       = bus_valid_i && flush_i;

    // Array write select: flushes in IDLE use the bus index, owner flushes in WAIT use the latched one.
    always_comb begin
        w_we   = 1'b0;
        w_widx = w_idx;
        if (r_state == S_IDLE && w_flush) begin
            w_we = 1'b1;
        end else if (r_state == S_WAIT && w_flush) begin
            w_we   = 1'b1;
            w_widx = r_idx;
        end
    end

    // Backing line array, reinitialised to the CAFE pattern on every reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MEM_LINES; i++) begin
                r_mem[i] <= RESET_LINE;
            end
        end else if (w_we) begin
            r_mem[w_widx] <= flush_data_i;
        end
    end

    // Request FSM with registered busy/fill outputs.
    // The counter is loaded with MEM_LATENCY and the RESP transition fires when it reads 1,
    // so data_valid_o rises exactly MEM_LATENCY edges after the request edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_data_valid <= 1'b0;
                    r_data       <= '0;
                    if (w_rd_req) begin
                        r_idx   <= w_idx;
                        r_cnt   <= 4'(MEM_LATENCY);
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_flush) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt        <= '0;
                        r_data       <= r_mem[r_idx];
                        r_data_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_data_valid <= 1'b0;
                    r_data       <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_data_valid <= 1'b0;
                    r_data       <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BUS_MEM_CTRL_ERR_EN
    logic r_err;

    // Sticky protocol error: request while busy, or flush without a granted transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if ((w_rd_req && r_busy) || (flush_i && !bus_valid_i)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    assign mem_busy_o   = r_busy;
    assign data_o       = r_data;
    assign data_valid_o = r_data_valid;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb_bus_mem_ctrl: directed, table-driven bench for bus_mem_ctrl.
// Each vector drives inputs for one clock edge and lists the outputs expected after it.
module tb_bus_mem_ctrl;

    localparam logic [127:0] CAFE = {8{16'hCAFE}};
    localparam logic [127:0] DEAD = {8{16'hDEAD}};
    localparam logic [127:0] WB   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] PAT  = {4{32'h1357_9BDF}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bus_valid = 1'b0;
    logic [1:0]   bus_msg = 2'b11;
    logic [31:0]  bus_addr = '0;
    logic         flush = 1'b0;
    logic [127:0] flush_data = '0;
    logic         busy;
    logic [127:0] data;
    logic         dvalid;
`ifdef BUS_MEM_CTRL_ERR_EN
    logic         err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string        name;
        logic         v;
        logic [1:0]   msg;
        logic [31:0]  addr;
        logic         fl;
        logic [127:0] fd;
        logic         ebusy;
        logic         edv;
        logic [127:0] edata;
    } vec_t;

    vec_t vq[$];

    bus_mem_ctrl #(
        .ADDR_SIZE      (32),
        .CACHE_LINE_SIZE(128),
        .MEM_LINES      (16),
        .MEM_LATENCY    (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus_valid_i (bus_valid),
        .bus_msg_i   (bus_msg),
        .bus_addr_i  (bus_addr),
        .flush_i     (flush),
        .flush_data_i(flush_data),
`ifdef BUS_MEM_CTRL_ERR_EN
        .err_o       (err),
`endif
        .mem_busy_o  (busy),
        .data_o      (data),
        .data_valid_o(dvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic v, input logic [1:0] msg, input logic [31:0] a,
                       input logic fl, input logic [127:0] fd,
                       input logic eb, input logic edv, input logic [127:0] ed);
        vec_t t;
        t.name = n; t.v = v; t.msg = msg; t.addr = a; t.fl = fl; t.fd = fd;
        t.ebusy = eb; t.edv = edv; t.edata = ed;
        vq.push_back(t);
    endtask

    task automatic idle(input string n, input int cycles, input logic eb);
        for (int i = 0; i < cycles; i++) add(n, 1'b0, 2'b11, 32'h0, 1'b0, '0, eb, 1'b0, '0);
    endtask

    // Complete fill: request edge T, busy T..T+4, pulse at T+4, idle at T+5.
    task automatic rd(input string n, input logic [1:0] msg, input logic [31:0] a, input logic [127:0] d);
        add({n, "_req"}, 1'b1, msg, a, 1'b0, '0, 1'b1, 1'b0, '0);
        idle({n, "_wait"}, 3, 1'b1);
        add({n, "_pulse"}, 1'b0, 2'b11, 32'h0, 1'b0, '0, 1'b1, 1'b1, d);
        add({n, "_done"}, 1'b0, 2'b11, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic drive(input vec_t t);
        bus_valid  = t.v;
        bus_msg    = t.msg;
        bus_addr   = t.addr;
        flush      = t.fl;
        flush_data = t.fd;
    endtask

    task automatic run_vectors();
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            chk({vq[i].name, ".busy"}, 128'(busy), 128'(vq[i].ebusy));
            chk({vq[i].name, ".dvalid"}, 128'(dvalid), 128'(vq[i].edv));
            chk({vq[i].name, ".data"}, data, vq[i].edata);
        end
        vq.delete();
        @(negedge clk);
        bus_valid = 1'b0; bus_msg = 2'b11; bus_addr = '0; flush = 1'b0; flush_data = '0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 128'(busy), 128'(1'b0));
        chk("reset.dvalid", 128'(dvalid), 128'(1'b0));
        chk("reset.data", data, '0);
`ifdef BUS_MEM_CTRL_ERR_EN
        chk("reset.err", 128'(err), 128'(1'b0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1: plain fill returns reset pattern
        idle("pre", 1, 1'b0);
        rd("rd30", 2'b00, 32'h30, CAFE);
        // 2: write-back, then fills of the line and of an alias; second request mid-WAIT ignored
        add("wb20", 1'b1, 2'b11, 32'h20, 1'b1, WB, 1'b0, 1'b0, '0);
        rd("rd20", 2'b00, 32'h20, WB);
        add("rd120_req", 1'b1, 2'b00, 32'h120, 1'b0, '0, 1'b1, 1'b0, '0);
        add("rd120_viol", 1'b1, 2'b00, 32'h0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle("rd120_wait", 2, 1'b1);
        add("rd120_pulse", 1'b0, 2'b11, 32'h0, 1'b0, '0, 1'b1, 1'b1, WB);
        add("rd120_done", 1'b0, 2'b11, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
        // 3: owner flush cancels BusRdX; flush goes to the latched index, not the bus address
        add("rdx40_req", 1'b1, 2'b01, 32'h40, 1'b0, '0, 1'b1, 1'b0, '0);
        idle("rdx40_wait", 1, 1'b1);
        add("rdx40_flush", 1'b1, 2'b01, 32'h0, 1'b1, DEAD, 1'b0, 1'b0, '0);
        idle("rdx40_nopulse", 3, 1'b0);
        rd("rd40", 2'b00, 32'h40, DEAD);
        rd("rd00", 2'b00, 32'h00, CAFE);
        // 4: BusUpgr without flush is ignored
        add("upgr10", 1'b1, 2'b10, 32'h10, 1'b0, '0, 1'b0, 1'b0, '0);
        idle("upgr10_quiet", 4, 1'b0);
        rd("rd10", 2'b00, 32'h10, CAFE);
        // Flush with request in IDLE writes and gives no response
        add("flushrd60", 1'b1, 2'b00, 32'h60, 1'b1, PAT, 1'b0, 1'b0, '0);
        idle("flushrd60_quiet", 4, 1'b0);
        rd("rd60", 2'b01, 32'h60, PAT);
        // Flush without a grant does not touch the array
        add("stray70", 1'b0, 2'b00, 32'h70, 1'b1, DEAD, 1'b0, 1'b0, '0);
        rd("rd70", 2'b00, 32'h70, CAFE);
        run_vectors();

        // 5: asynchronous reset in the middle of WAIT
        bus_valid = 1'b1; bus_msg = 2'b00; bus_addr = 32'h50;
        @(posedge clk); #1;
        chk("rst_mid.req_busy", 128'(busy), 128'(1'b1));
        @(negedge clk);
        bus_valid = 1'b0; bus_msg = 2'b11; bus_addr = '0;
        @(posedge clk); #1;
        chk("rst_mid.wait_busy", 128'(busy), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.async_busy", 128'(busy), 128'(1'b0));
        chk("rst_mid.async_dvalid", 128'(dvalid), 128'(1'b0));
        chk("rst_mid.async_data", data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_mid.nopulse", 128'(dvalid), 128'(1'b0));
        end
        rd("rst_rd20", 2'b00, 32'h20, CAFE);
        run_vectors();

`ifdef BUS_MEM_CTRL_ERR_EN
        // 6: second request while busy sets err_o; first fill still completes
        chk("err.before", 128'(err), 128'(1'b0));
        add("err_req30", 1'b1, 2'b00, 32'h30, 1'b0, '0, 1'b1, 1'b0, '0);
        add("err_req40", 1'b1, 2'b00, 32'h40, 1'b0, '0, 1'b1, 1'b0, '0);
        idle("err_wait", 2, 1'b1);
        add("err_pulse", 1'b0, 2'b11, 32'h0, 1'b0, '0, 1'b1, 1'b1, CAFE);
        add("err_done", 1'b0, 2'b11, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
        run_vectors();
        chk("err.sticky", 128'(err), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("err.cleared", 128'(err), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
